// File: rtl/rx_fifo_module_if.sv
// Byte-buffer bus between the UART receive path / host logic and rx_fifo_module.
// Master side drives the write strobe, pop request and flush; slave side is the FIFO.
interface rx_fifo_module_if #(
   parameter int ADDR_WIDTH = 4
);
   // Write side: one byte per rising edge of Rx_Done_Sig, Rx_Data stable while it is high.
   // Read side: Rd_En_Sig pops only when Empty_Sig is low. Rd_Valid_Sig qualifies Rd_Data.
   logic                  Rx_Done_Sig;
   logic [7:0]            Rx_Data;
   logic                  Rd_En_Sig;
   logic                  Clr_Sig;
   logic [7:0]            Rd_Data;
   logic                  Rd_Valid_Sig;
   logic                  Empty_Sig;
   logic                  Full_Sig;
   logic [ADDR_WIDTH:0]   Level;
   logic                  Ovf_Sig;

   modport master (
      output Rx_Done_Sig, Rx_Data, Rd_En_Sig, Clr_Sig,
      input  Rd_Data, Rd_Valid_Sig, Empty_Sig, Full_Sig, Level, Ovf_Sig
   );

   modport slave (
      input  Rx_Done_Sig, Rx_Data, Rd_En_Sig, Clr_Sig,
      output Rd_Data, Rd_Valid_Sig, Empty_Sig, Full_Sig, Level, Ovf_Sig
   );
endinterface

// File: rtl/rx_fifo_module.sv
// Receive-side circular byte FIFO with edge-detected write strobe and sticky overflow flag.
// Define RX_FIFO_FWFT_EN for first-word fall-through reads; default is a registered read.
module rx_fifo_module #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic              CLK,
   input  logic              RST_n,
   rx_fifo_module_if.slave   bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   LVL_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [7:0]            mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [ADDR_WIDTH:0]   level;
   logic [ADDR_WIDTH:0]   level_nxt;
   logic                  full_q;
   logic                  empty_q;
   logic                  ovf_q;
   logic                  done_prev;
   logic                  wr_strobe;
   logic                  rd_acc;
   logic                  wr_acc;

   assign wr_strobe = bus.Rx_Done_Sig & ~done_prev;
   assign rd_acc    = bus.Rd_En_Sig & ~empty_q;
   // A full FIFO still takes a byte when the same cycle frees a slot.
   assign wr_acc    = wr_strobe & (~full_q | rd_acc);

   always_comb begin
      level_nxt = level;
      case ({wr_acc, rd_acc})
         2'b10:   level_nxt = level + LVL_ONE;
         2'b01:   level_nxt = level - LVL_ONE;
         default: level_nxt = level;
      endcase
   end

   // Storage is deliberately left out of reset and flush.
   always_ff @(posedge CLK) begin
      if (wr_acc && !bus.Clr_Sig) begin
         mem[wptr] <= bus.Rx_Data;
      end
   end

`ifdef RX_FIFO_FWFT_EN
   assign bus.Rd_Data      = mem[rptr];
   assign bus.Rd_Valid_Sig = ~empty_q;
`else
   logic [7:0] rd_data_q;
   logic       rd_valid_q;
   assign bus.Rd_Data      = rd_data_q;
   assign bus.Rd_Valid_Sig = rd_valid_q;
`endif

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         wptr      <= '0;
         rptr      <= '0;
         level     <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         ovf_q     <= 1'b0;
         done_prev <= 1'b0;
`ifndef RX_FIFO_FWFT_EN
         rd_data_q  <= 8'h00;
         rd_valid_q <= 1'b0;
`endif
      end else begin
         // Edge register keeps tracking during a flush so an overlapping pulse is lost.
         done_prev <= bus.Rx_Done_Sig;
         if (bus.Clr_Sig) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
`ifndef RX_FIFO_FWFT_EN
            rd_valid_q <= 1'b0;
`endif
         end else begin
            if (wr_acc) wptr <= wptr + PTR_ONE;
            if (rd_acc) rptr <= rptr + PTR_ONE;
            level   <= level_nxt;
            full_q  <= (level_nxt == DEPTH_LVL);
            empty_q <= (level_nxt == '0);
            if (wr_strobe && !wr_acc) ovf_q <= 1'b1;
`ifndef RX_FIFO_FWFT_EN
            if (rd_acc) begin
               rd_data_q  <= mem[rptr];
               rd_valid_q <= 1'b1;
            end else begin
               rd_valid_q <= 1'b0;
            end
`endif
         end
      end
   end

   assign bus.Level     = level;
   assign bus.Full_Sig  = full_q;
   assign bus.Empty_Sig = empty_q;
   assign bus.Ovf_Sig   = ovf_q;
endmodule

// File: tb/tb_rx_fifo_module.sv
// Directed bench for rx_fifo_module: queue-based reference model compared every cycle,
// plus literal expectations from the worked scenarios. Works with or without RX_FIFO_FWFT_EN.
module tb_rx_fifo_module;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic CLK;
   logic RST_n;
   int   n_checks;
   int   n_errors;

   rx_fifo_module_if #(.ADDR_WIDTH(AW)) bus_if ();

   rx_fifo_module #(.ADDR_WIDTH(AW)) dut (
      .CLK   (CLK),
      .RST_n (RST_n),
      .bus   (bus_if)
   );

   // ---------------- clock / reset ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   logic [7:0] exp_q[$];
   logic       m_prev;
   logic       m_ovf;
   logic       m_valid;
   logic [7:0] m_data;

   task automatic model_reset();
      exp_q.delete();
      m_prev  = 1'b0;
      m_ovf   = 1'b0;
      m_valid = 1'b0;
      m_data  = 8'h00;
   endtask

   task automatic model_step();
      logic strobe;
      logic rd;
      logic wr;
      strobe = bus_if.Rx_Done_Sig && !m_prev;
      m_prev = bus_if.Rx_Done_Sig;
      if (bus_if.Clr_Sig) begin
         exp_q.delete();
         m_ovf   = 1'b0;
         m_valid = 1'b0;
      end else begin
         rd = bus_if.Rd_En_Sig && (exp_q.size() > 0);
         wr = strobe && ((exp_q.size() < DEPTH) || rd);
         if (rd) begin
            m_data  = exp_q.pop_front();
            m_valid = 1'b1;
         end else begin
            m_valid = 1'b0;
         end
         if (wr) exp_q.push_back(bus_if.Rx_Data);
         else if (strobe) m_ovf = 1'b1;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLK);
         if (RST_n) model_step();
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic       e_valid;
      logic [7:0] e_data;
      forever begin
         @(negedge CLK);
`ifdef RX_FIFO_FWFT_EN
         e_valid = (exp_q.size() != 0);
         e_data  = e_valid ? exp_q[0] : 8'h00;
`else
         e_valid = m_valid;
         e_data  = m_data;
`endif
         check("cmp_level", 32'(bus_if.Level), 32'(exp_q.size()));
         check("cmp_empty", 32'(bus_if.Empty_Sig), 32'(exp_q.size() == 0));
         check("cmp_full",  32'(bus_if.Full_Sig),  32'(exp_q.size() == DEPTH));
         check("cmp_ovf",   32'(bus_if.Ovf_Sig),   32'(m_ovf));
         check("cmp_valid", 32'(bus_if.Rd_Valid_Sig), 32'(e_valid));
         if (e_valid || !RST_n) begin
`ifdef RX_FIFO_FWFT_EN
            if (e_valid) check("cmp_data", 32'(bus_if.Rd_Data), 32'(e_data));
`else
            check("cmp_data", 32'(bus_if.Rd_Data), 32'(e_data));
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b);
      bus_if.Rx_Data     = b;
      bus_if.Rx_Done_Sig = 1'b1;
      tick();
      bus_if.Rx_Done_Sig = 1'b0;
      tick();
   endtask

   task automatic pop_check(input string name, input logic [7:0] exp);
`ifdef RX_FIFO_FWFT_EN
      check(name, 32'(bus_if.Rd_Data), 32'(exp));
      check({name, "_v"}, 32'(bus_if.Rd_Valid_Sig), 32'd1);
`endif
      bus_if.Rd_En_Sig = 1'b1;
      tick();
      bus_if.Rd_En_Sig = 1'b0;
`ifndef RX_FIFO_FWFT_EN
      check(name, 32'(bus_if.Rd_Data), 32'(exp));
      check({name, "_v"}, 32'(bus_if.Rd_Valid_Sig), 32'd1);
`endif
   endtask

   // Write strobe and pop in the same edge; exp is the byte the pop returns.
   task automatic wr_rd_same(input logic [7:0] b, input logic [7:0] exp);
`ifdef RX_FIFO_FWFT_EN
      check("same_cycle_data", 32'(bus_if.Rd_Data), 32'(exp));
`endif
      bus_if.Rx_Data     = b;
      bus_if.Rx_Done_Sig = 1'b1;
      bus_if.Rd_En_Sig   = 1'b1;
      tick();
      bus_if.Rx_Done_Sig = 1'b0;
      bus_if.Rd_En_Sig   = 1'b0;
`ifndef RX_FIFO_FWFT_EN
      check("same_cycle_data", 32'(bus_if.Rd_Data), 32'(exp));
`endif
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      bus_if.Rx_Done_Sig = 1'b0;
      bus_if.Rx_Data     = 8'h00;
      bus_if.Rd_En_Sig   = 1'b0;
      bus_if.Clr_Sig     = 1'b0;
      RST_n = 1'b0;
      model_reset();
      repeat (2) tick();
      check("rst_level", 32'(bus_if.Level), 32'd0);
      check("rst_empty", 32'(bus_if.Empty_Sig), 32'd1);
      check("rst_full",  32'(bus_if.Full_Sig), 32'd0);
      check("rst_ovf",   32'(bus_if.Ovf_Sig), 32'd0);
      check("rst_valid", 32'(bus_if.Rd_Valid_Sig), 32'd0);
`ifndef RX_FIFO_FWFT_EN
      check("rst_data",  32'(bus_if.Rd_Data), 32'h00);
`endif
      RST_n = 1'b1;
      tick();

      // Single byte round trip.
      write_byte(8'hA5);
      check("a5_level1", 32'(bus_if.Level), 32'd1);
      pop_check("a5_data", 8'hA5);
      check("a5_level0", 32'(bus_if.Level), 32'd0);
      check("a5_empty",  32'(bus_if.Empty_Sig), 32'd1);
      tick();
      check("a5_valid_drop", 32'(bus_if.Rd_Valid_Sig), 32'd0);
`ifndef RX_FIFO_FWFT_EN
      check("a5_data_hold", 32'(bus_if.Rd_Data), 32'hA5);
`endif

      // Long done pulse stores one byte.
      bus_if.Rx_Data     = 8'h3C;
      bus_if.Rx_Done_Sig = 1'b1;
      repeat (5) tick();
      bus_if.Rx_Done_Sig = 1'b0;
      tick();
      check("hold_level", 32'(bus_if.Level), 32'd1);
      pop_check("hold_data", 8'h3C);
      tick();

      // Overfill by one, then drain in order.
      for (int i = 0; i < 17; i++) write_byte(8'(i));
      check("ovf_level", 32'(bus_if.Level), 32'd16);
      check("ovf_full",  32'(bus_if.Full_Sig), 32'd1);
      check("ovf_flag",  32'(bus_if.Ovf_Sig), 32'd1);
      for (int i = 0; i < 16; i++) pop_check("drain_data", 8'(i));
      tick();
      check("drain_empty", 32'(bus_if.Empty_Sig), 32'd1);
      check("ovf_sticky",  32'(bus_if.Ovf_Sig), 32'd1);
      bus_if.Clr_Sig = 1'b1;
      tick();
      bus_if.Clr_Sig = 1'b0;
      check("clr_ovf", 32'(bus_if.Ovf_Sig), 32'd0);

      // Offset the pointers, fill, then write+read while full across the wrap.
      for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i));
      for (int i = 0; i < 5; i++) pop_check("offset_data", 8'h30 + 8'(i));
      for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i));
      check("wrap_full", 32'(bus_if.Full_Sig), 32'd1);
      wr_rd_same(8'h55, 8'h40);
      check("wrap_level", 32'(bus_if.Level), 32'd16);
      check("wrap_ovf",   32'(bus_if.Ovf_Sig), 32'd0);
      tick();
      for (int i = 1; i < 16; i++) pop_check("wrap_data", 8'h40 + 8'(i));
      pop_check("wrap_last", 8'h55);
      tick();

      // Level 3 with overflow set, then flush overlapping a done pulse.
      for (int i = 0; i < 17; i++) write_byte(8'h60 + 8'(i));
      for (int i = 0; i < 13; i++) pop_check("pre_clr_data", 8'h60 + 8'(i));
      check("pre_clr_level", 32'(bus_if.Level), 32'd3);
      check("pre_clr_ovf",   32'(bus_if.Ovf_Sig), 32'd1);
      bus_if.Clr_Sig     = 1'b1;
      bus_if.Rx_Data     = 8'h77;
      bus_if.Rx_Done_Sig = 1'b1;
      tick();
      bus_if.Clr_Sig = 1'b0;
      tick();
      bus_if.Rx_Done_Sig = 1'b0;
      tick();
      check("clr_level", 32'(bus_if.Level), 32'd0);
      check("clr_empty", 32'(bus_if.Empty_Sig), 32'd1);
      check("clr_ovf2",  32'(bus_if.Ovf_Sig), 32'd0);
      check("clr_valid", 32'(bus_if.Rd_Valid_Sig), 32'd0);

      // Write and read together on empty: the read is ignored.
      bus_if.Rx_Data     = 8'h99;
      bus_if.Rx_Done_Sig = 1'b1;
      bus_if.Rd_En_Sig   = 1'b1;
      tick();
      bus_if.Rx_Done_Sig = 1'b0;
      bus_if.Rd_En_Sig   = 1'b0;
      check("empty_wr_rd_level", 32'(bus_if.Level), 32'd1);
`ifndef RX_FIFO_FWFT_EN
      check("empty_wr_rd_valid", 32'(bus_if.Rd_Valid_Sig), 32'd0);
`endif
      pop_check("empty_wr_rd_data", 8'h99);
      tick();

`ifdef RX_FIFO_FWFT_EN
      // Fall-through display after each write and pop.
      write_byte(8'h11);
      check("fwft_first", 32'(bus_if.Rd_Data), 32'h11);
      check("fwft_first_v", 32'(bus_if.Rd_Valid_Sig), 32'd1);
      write_byte(8'h22);
      pop_check("fwft_pop1", 8'h11);
      check("fwft_second", 32'(bus_if.Rd_Data), 32'h22);
      pop_check("fwft_pop2", 8'h22);
      check("fwft_empty_v", 32'(bus_if.Rd_Valid_Sig), 32'd0);
`endif

      // Pop request on empty changes nothing.
      bus_if.Rd_En_Sig = 1'b1;
      repeat (2) tick();
      bus_if.Rd_En_Sig = 1'b0;
      check("empty_pop_level", 32'(bus_if.Level), 32'd0);
      check("empty_pop_ovf",   32'(bus_if.Ovf_Sig), 32'd0);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
